// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART TX FIFO write port among NUM_REQ requesters.
// Every granted packet is prefixed with a {HDR_TAG, id} byte; a watchdog aborts starved grants.
module uart_tx_arbiter #(
    parameter int         DATA_WIDTH = 8,
    parameter int         NUM_REQ    = 4,
    parameter logic [3:0] HDR_TAG    = 4'hA,
    parameter int         TIMEOUT    = 64
) (
    input  logic                          UCLK,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          tx_full,
    output logic [DATA_WIDTH-1:0]         W_data,
    output logic                          wr_uart,
    output logic [3:0]                    grant_id,
    output logic                          busy,
    output logic                          timeout_err,
    output logic [3:0]                    err_id
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [3:0]      err_id_q, err_id_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   wd_cnt_q, wd_cnt_d;

    logic                  cur_valid, cur_last, xfer, sel_found;
    logic [DATA_WIDTH-1:0] cur_data, hdr_byte;
    logic [NUM_REQ-1:0]    rot;
    logic [IW-1:0]         sel_idx;
    int                    sel_sum;

    assign grant_id = 4'(gnt_q);
    assign err_id   = err_id_q;
    assign busy     = busy_q;

    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q == IW'(i)) begin
                cur_valid = req_valid[i];
                cur_last  = req_last[i];
                cur_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        hdr_byte      = '0;
        hdr_byte[7:0] = {HDR_TAG, 4'(gnt_q)};
    end

    // Rotate so bit 0 is requester ptr+1; the first set bit wins.
    always_comb begin
        rot       = NUM_REQ'({req_valid, req_valid} >> ({1'b0, ptr_q} + 1'b1));
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_sum   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_found && rot[k]) begin
                sel_found = 1'b1;
                sel_sum   = int'(ptr_q) + 1 + k;
                if (sel_sum >= NUM_REQ) sel_sum = sel_sum - NUM_REQ;
                sel_idx   = IW'(sel_sum);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        err_id_d    = err_id_q;
        wd_cnt_d    = wd_cnt_q;
        wr_uart     = 1'b0;
        W_data      = '0;
        req_ready   = '0;
        timeout_err = 1'b0;
        xfer        = cur_valid && !tx_full;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    gnt_d   = sel_idx;
                    state_d = HDR;
                end
            end
            HDR: begin
                W_data  = hdr_byte;
                wr_uart = !tx_full;
                if (!tx_full) begin
                    state_d  = PAY;
                    wd_cnt_d = '0;
                end
            end
            PAY: begin
                W_data  = cur_data;
                wr_uart = xfer;
                for (int i = 0; i < NUM_REQ; i++)
                    req_ready[i] = (gnt_q == IW'(i)) && !tx_full;
                if (xfer) begin
                    wd_cnt_d = '0;
                    if (cur_last) begin
                        ptr_d   = gnt_q;
                        state_d = IDLE;
                    end
                end else if (!cur_valid) begin
                    // Full-but-valid cycles fall through: neither counted nor cleared.
                    if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
                        timeout_err = 1'b1;
                        err_id_d    = 4'(gnt_q);
                        ptr_d       = gnt_q;
                        state_d     = IDLE;
                        wd_cnt_d    = '0;
                    end else begin
                        wd_cnt_d = wd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= IW'(NUM_REQ - 1);
            gnt_q    <= '0;
            err_id_q <= '0;
            busy_q   <= 1'b0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            err_id_q <= err_id_d;
            busy_q   <= busy_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin packet arbiter that shares the single UART transmit path (the `W_data` / `wr_uart` / `tx_full` write port of the UART TX FIFO) among `NUM_REQ` independent requesters. It grants one requester at a time for a whole packet, delimited by a `last` flag. Each forwarded packet is prefixed with a one-byte header identifying the source, so the far end can demultiplex. A stall watchdog releases the grant if the owning requester stops supplying data.

## Interface
Parameters:
- `DATA_WIDTH`, 8: UART character width; must be ≥ 8.
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `HDR_TAG`, 4'hA: upper nibble of the header byte.
- `TIMEOUT`, 64: consecutive starved cycles before the grant is aborted; must be ≥ 2.

Ports:
- `UCLK` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: requester i has a byte available.
- `req_data` in NUM_REQ*DATA_WIDTH: requester i's byte in slice [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last` in NUM_REQ: the byte from requester i is the final byte of its packet.
- `req_ready` out NUM_REQ: byte from requester i is accepted this cycle.
- `tx_full` in 1: UART TX FIFO full.
- `W_data` out DATA_WIDTH: byte to the UART TX FIFO.
- `wr_uart` out 1: write strobe to the UART TX FIFO, one byte per high cycle.
- `grant_id` out 4: current or most recent owner (registered).
- `busy` out 1: a packet is in progress (HDR or PAY state).
- `timeout_err` out 1: one-cycle pulse when a grant is aborted.
- `err_id` out 4: owner at the last abort; held until the next abort.

## Operation
- FSM states: IDLE, HDR, PAY.
- IDLE:
  - If any `req_valid` is high, select the first set bit scanning from `ptr+1` upward, modulo NUM_REQ.
  - Register the selection into `grant_id`, then go to HDR.
  - `ptr` is the last requester that completed or aborted a packet.
- HDR:
  - `W_data` = {zeros, HDR_TAG, grant_id}.
  - `wr_uart` = !tx_full.
  - When a write occurs, go to PAY.
  - The header does not require `req_valid`.
- PAY:
  - `req_ready[grant_id]` = !tx_full; all other `req_ready` bits are 0.
  - A transfer occurs when `req_valid[g]` and `req_ready[g]` are both high (g = grant_id).
  - On a transfer: `wr_uart`=1 and `W_data` = req_data slice g.
  - On a transfer with `req_last[g]` high: `ptr`←g, go to IDLE.
- Watchdog:
  - Counts PAY cycles where `req_valid[g]`=0.
  - Cleared on each transfer and on entry to PAY.
  - Cycles with tx_full=1 and `req_valid[g]`=1 do not count, and do not clear the counter.
  - When the count reaches TIMEOUT:
    - pulse `timeout_err` and set `err_id`←g;
    - set `ptr`←g and go to IDLE;
    - nothing further is written for that packet (truncated packet).
- Non-granted requesters are never acknowledged. They hold their data until granted.
- `req_last` is sampled only on a transfer.
- `wr_uart`, `W_data` and `req_ready` are combinational from registered state plus `tx_full`, `req_valid` and `req_data`. `wr_uart` is never high while tx_full=1.
- In IDLE: `wr_uart`=0, `req_ready`=0, and `W_data`=0.

## Timing
- Reset (async, takes effect immediately):
  - state IDLE;
  - `ptr`=NUM_REQ-1, so requester 0 has first priority;
  - `grant_id`=0, `err_id`=0, `busy`=0, `timeout_err`=0, `wr_uart`=0, `req_ready`=0, `W_data`=0;
  - watchdog counter=0.
- Reset mid-packet: the packet is dropped and no further write occurs. After release, arbitration restarts from requester 0.
- Latency with tx_full=0:
  - `req_valid` seen in IDLE at cycle 0;
  - header written in cycle 1;
  - first payload byte written in cycle 2 at the earliest.
- Payload throughput: 1 byte per cycle.
- Between packets: one IDLE cycle after the last byte, then a header cycle. A new packet therefore costs 2 cycles of overhead.
- tx_full stall: the header or byte is held, `req_ready`=0, and no data is lost. Data resumes on the first cycle with tx_full=0.
- Simultaneous requests: at most one grant per IDLE cycle. Requesters that are not selected keep waiting.
- `timeout_err` is high in exactly the cycle where state goes PAY→IDLE due to the watchdog.
- `busy` is registered: high in HDR and PAY.

## Test plan
- Requester 1 sends 8'h11, 8'h22, 8'h33 (last on 8'h33), tx_full=0 → `wr_uart` writes A1, 11, 22, 33 on 4 consecutive cycles; `req_ready[1]` high for exactly 3 cycles.
- After reset, all 4 requesters each present one byte with last, data 8'hD0+i → output stream A0 D0 A1 D1 A2 D2 A3 D3; one IDLE cycle between packets.
- tx_full forced high for 20 cycles after the 2nd payload byte of a 4-byte packet → `wr_uart`=0 and `req_ready`=0 during the stall; `timeout_err` stays 0; remaining bytes follow in order.
- Granted requester 2 drops `req_valid` after 1 byte for TIMEOUT cycles, with TIMEOUT=64 → `timeout_err` pulses in cycle 64 of starvation; `err_id`=2; pending requester 3 is granted next and header A3 appears.
- Reset asserted mid-payload of requester 3 → `wr_uart`, `busy` and `req_ready` drop to 0 in the same cycle; after release, with 0 and 3 both requesting, requester 0 is granted first.
- Requesters 0 and 2 continuously send 2-byte packets → headers alternate A0, A2, A0, A2; no requester is granted twice in a row while the other waits.
